// File: rtl/fifo_reader.sv
// Drains a FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// Pop-to-m_valid latency 1 cycle; pops stop when the buffer is full, so m_ready never reaches rinc.
module fifo_reader #(
    parameter int DATASIZE = 8,
    parameter int CNTW     = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                en,
    input  logic                flush,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [CNTW-1:0]     rd_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATASIZE-1:0] buf0;
    logic [DATASIZE-1:0] buf1;
    logic [1:0]          occ;
    logic                capture;
    logic                handshake;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                IDLE:    if (en)     state_nxt = RUN;
                RUN:     if (!en)    state_nxt = IDLE;
                FLUSH:   if (rempty) state_nxt = IDLE;
                default:             state_nxt = IDLE;
            endcase
        end
    end

    // Occupancy-gated pop keeps m_ready off the rinc path.
    always_comb begin
        rinc = 1'b0;
        if (!rempty) begin
            if (state == RUN && occ < 2'd2) rinc = 1'b1;
            if (state == FLUSH)             rinc = 1'b1;
        end
    end

    // A pop coinciding with a flush request is discarded along with the buffer.
    assign capture   = rinc && (state == RUN) && !flush;
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0;
    assign handshake = m_valid && m_ready;
    assign busy      = (state != IDLE) || m_valid;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else if (flush || state == FLUSH) begin
            occ <= 2'd0;
        end else begin
            case ({capture, handshake})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= rdata;
                    else             buf1 <= rdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word arrives: shift and refill, occupancy unchanged.
                    if (occ == 2'd1) begin
                        buf0 <= rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_count <= '0;
        end else if (capture && rd_count != {CNTW{1'b1}}) begin
            rd_count <= rd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench: the bench plays the FIFO, predicts delivered words in a queue, and a monitor checks the stream.
`timescale 1ns/1ps
module tb_fifo_reader;

    localparam int DW   = 8;
    localparam int CW   = 5;
    localparam int CMAX = 31;

    typedef enum int {M_IDLE, M_RUN, M_FLUSH} mode_t;

    logic          rclk;
    logic          rrst_n;
    logic          en;
    logic          flush;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] rd_count;
    logic          busy;

    fifo_reader #(.DATASIZE(DW), .CNTW(CW)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .en       (en),
        .flush    (flush),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .rd_count (rd_count),
        .busy     (busy)
    );

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    mode_t         mode;
    int            model_cnt;
    int            delivered;
    int            pops;
    int            checks;
    int            errors;
    bit            refill;

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: sees the stream two units after each falling edge.
    initial begin
        forever begin
            @(negedge rclk);
            #2;
            chk("m_valid", m_valid, exp_q.size() != 0);
            if (m_valid && exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
            chk("rd_count", rd_count, model_cnt);
            chk("busy", busy, (mode != M_IDLE) || (exp_q.size() != 0));
            if (m_valid && m_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                delivered++;
            end
        end
    end

    // One clock of stimulus: drive at the falling edge, predict what the next rising edge does.
    task automatic cycle(input bit e, input bit f, input bit r);
        bit            exp_rinc;
        bit            popped;
        logic [DW-1:0] w;
        @(negedge rclk);
        en      = e;
        flush   = f;
        m_ready = r;
        rempty  = (fifo_q.size() == 0);
        rdata   = rempty ? '0 : fifo_q[0];
        #1;
        exp_rinc = !rempty && ((mode == M_RUN && exp_q.size() < 2) || mode == M_FLUSH);
        chk("rinc", rinc, exp_rinc);
        popped = rinc && !rempty;
        #2;
        if (popped) begin
            w = fifo_q.pop_front();
            pops++;
            if (mode == M_RUN && !f) begin
                exp_q.push_back(w);
                if (model_cnt < CMAX) model_cnt++;
            end
        end
        if (f) exp_q.delete();
        if (f)                                    mode = M_FLUSH;
        else if (mode == M_IDLE && e)             mode = M_RUN;
        else if (mode == M_RUN && !e)             mode = M_IDLE;
        else if (mode == M_FLUSH && rempty)       mode = M_IDLE;
        if (refill && fifo_q.size() < 10 && $urandom_range(1, 0) == 1)
            fifo_q.push_back(DW'($urandom));
    endtask

    task automatic do_reset();
        @(negedge rclk);
        en      = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        rrst_n  = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_rinc", rinc, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data", m_data, 0);
        exp_q.delete();
        mode      = M_IDLE;
        model_cnt = 0;
        delivered = 0;
        pops      = 0;
        @(negedge rclk);
        #1 rrst_n = 1'b1;
    endtask

    task automatic load(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    endtask

    initial begin
        checks = 0; errors = 0; refill = 1'b0;
        rrst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        rempty = 1'b1; rdata = '0;
        mode = M_IDLE; model_cnt = 0; delivered = 0; pops = 0;
        do_reset();

        // Full-rate drain of a known pattern.
        fifo_q = '{8'h00, 8'hFF, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
        repeat (11) cycle(1, 0, 1);
        chk("s1_delivered", delivered, 9);
        chk("s1_rd_count", rd_count, 9);
        repeat (2) cycle(0, 0, 1);

        // Stalled downstream: two pops then hold.
        do_reset();
        fifo_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        repeat (8) cycle(1, 0, 0);
        chk("s2_pops", pops, 2);
        chk("s2_hold", m_data, 8'h00);
        repeat (12) cycle(1, 0, 1);
        chk("s2_delivered", delivered, 9);

        // Toggling ready.
        do_reset();
        load(16);
        for (int i = 0; i < 40; i++) cycle(1, 0, i[0]);
        chk("s3_delivered", delivered, 16);
        chk("s3_rd_count", rd_count, 16);

        // Flush with 2 buffered and 5 in FIFO.
        do_reset();
        load(7);
        repeat (4) cycle(1, 0, 0);
        pops = 0;
        cycle(1, 1, 0);
        repeat (8) cycle(0, 0, 0);
        chk("s4_pops", pops, 5);
        chk("s4_rd_count", rd_count, 2);
        chk("s4_busy", busy, 0);

        // en dropped mid-stream: buffered words still drain, no pops in IDLE.
        do_reset();
        load(1);
        repeat (2) cycle(1, 0, 0);
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h5A);
        cycle(0, 0, 0);
        pops = 0;
        repeat (3) cycle(0, 0, 0);
        chk("s5_pops", pops, 0);
        repeat (3) cycle(0, 0, 1);
        chk("s5_delivered", delivered, 2);
        chk("s5_busy", busy, 0);

        // Counter saturation.
        do_reset();
        load(40);
        repeat (50) cycle(1, 0, 1);
        chk("s6_sat", rd_count, CMAX);

        // Random traffic with a mid-stream reset.
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle($urandom_range(7, 0) != 0, $urandom_range(23, 0) == 0, $urandom_range(1, 0) == 1);
        end
        refill = 1'b0;
        repeat (20) cycle(0, 0, 1);
        chk("final_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
